// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - control bus between the multicycle controller and the ARMCPU datapath
interface multicycle_controller_if #(
    parameter int INSTR_W  = 16,
    parameter int ALUCTL_W = 5
);
    logic [INSTR_W-1:0]  instr;
    logic [3:0]          alu_flags;
    logic                mem_ready;
    logic                irwrite;
    logic                pcwrite;
    logic                adrsrc;
    logic                memwrite;
    logic                regwrite;
    logic [1:0]          resultsrc;
    logic                alusrca;
    logic [1:0]          alusrcb;
    logic [ALUCTL_W-1:0] alucontrol;
    logic [1:0]          immsrc;
    logic [3:0]          flags;
    logic                cond_fail;
    logic [3:0]          state;

    modport master (
        input  instr, alu_flags, mem_ready,
        output irwrite, pcwrite, adrsrc, memwrite, regwrite, resultsrc,
               alusrca, alusrcb, alucontrol, immsrc, flags, cond_fail, state
    );

    modport slave (
        output instr, alu_flags, mem_ready,
        input  irwrite, pcwrite, adrsrc, memwrite, regwrite, resultsrc,
               alusrca, alusrcb, alucontrol, immsrc, flags, cond_fail, state
    );
endinterface

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - Moore FSM multicycle control unit with NZCV flags; MCCTRL_MEM_WAIT_EN adds memory wait states
module multicycle_controller #(
    parameter int                  INSTR_W  = 16,
    parameter int                  ALUCTL_W = 5,
    parameter logic [ALUCTL_W-1:0] ALU_ADD  = ALUCTL_W'(5'd0)
) (
    input  logic                   clk,
    input  logic                   reset,
    multicycle_controller_if.master bus
);
    typedef enum logic [3:0] {
        S_RST    = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC   = 4'd3,
        S_ALUWB  = 4'd4,
        S_MEMADR = 4'd5,
        S_MEMRD  = 4'd6,
        S_MEMWB  = 4'd7,
        S_MEMWR  = 4'd8,
        S_BRANCH = 4'd9,
        S_LDI    = 4'd10
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] flags_q, flags_d;

    logic [3:0] cond;
    logic [1:0] op;
    logic       sl;
    logic [4:0] fn;
    logic       cond_pass;
    logic       mem_ok;

    assign cond = bus.instr[INSTR_W-1:INSTR_W-4];
    assign op   = bus.instr[INSTR_W-5:INSTR_W-6];
    assign sl   = bus.instr[INSTR_W-7];
    assign fn   = bus.instr[INSTR_W-8:INSTR_W-12];

`ifdef MCCTRL_MEM_WAIT_EN
    assign mem_ok = bus.mem_ready;
    logic unused_low_bits;
    assign unused_low_bits = &{1'b0, bus.instr[INSTR_W-13:0]};
`else
    assign mem_ok = 1'b1;
    logic unused_low_bits;
    assign unused_low_bits = &{1'b0, bus.instr[INSTR_W-13:0], bus.mem_ready};
`endif

    // Condition is judged against the registered flags, never the live ALU flags.
    always_comb begin
        logic n, z, c, v;
        {n, z, c, v} = flags_q;
        cond_pass = 1'b0;
        case (cond)
            4'b0000: cond_pass = z;
            4'b0001: cond_pass = !z;
            4'b0010: cond_pass = c;
            4'b0011: cond_pass = !c;
            4'b0100: cond_pass = n;
            4'b0101: cond_pass = !n;
            4'b0110: cond_pass = v;
            4'b0111: cond_pass = !v;
            4'b1000: cond_pass = c && !z;
            4'b1001: cond_pass = !c || z;
            4'b1010: cond_pass = (n == v);
            4'b1011: cond_pass = (n != v);
            4'b1100: cond_pass = !z && (n == v);
            4'b1101: cond_pass = z || (n != v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_RST;
            flags_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        flags_d        = flags_q;
        bus.irwrite    = 1'b0;
        bus.pcwrite    = 1'b0;
        bus.adrsrc     = 1'b0;
        bus.memwrite   = 1'b0;
        bus.regwrite   = 1'b0;
        bus.resultsrc  = 2'b00;
        bus.alusrca    = 1'b0;
        bus.alusrcb    = 2'b00;
        bus.alucontrol = '0;
        bus.immsrc     = 2'b00;
        bus.cond_fail  = 1'b0;

        case (state_q)
            S_RST: state_d = S_FETCH;

            S_FETCH: begin
                bus.irwrite    = 1'b1;
                bus.pcwrite    = 1'b1;
                bus.alusrcb    = 2'b10;
                bus.alucontrol = ALU_ADD;
                bus.resultsrc  = 2'b10;
                if (mem_ok) state_d = S_DECODE;
            end

            S_DECODE: begin
                if (!cond_pass) begin
                    bus.cond_fail = 1'b1;
                    state_d       = S_FETCH;
                end else begin
                    case (op)
                        2'b00:   state_d = S_EXEC;
                        2'b01:   state_d = S_MEMADR;
                        2'b10:   state_d = S_BRANCH;
                        default: state_d = S_LDI;
                    endcase
                end
            end

            S_EXEC: begin
                bus.alusrca    = 1'b1;
                bus.alusrcb    = fn[4] ? 2'b01 : 2'b00;
                bus.alucontrol = ALUCTL_W'(fn);
                state_d        = S_ALUWB;
            end

            // The only place the flags register is ever loaded.
            S_ALUWB: begin
                bus.regwrite  = 1'b1;
                bus.resultsrc = 2'b00;
                if (sl) flags_d = bus.alu_flags;
                state_d = S_FETCH;
            end

            S_MEMADR: begin
                bus.alusrca    = 1'b1;
                bus.alusrcb    = 2'b01;
                bus.immsrc     = 2'b01;
                bus.alucontrol = ALU_ADD;
                state_d        = sl ? S_MEMRD : S_MEMWR;
            end

            S_MEMRD: begin
                bus.adrsrc = 1'b1;
                if (mem_ok) state_d = S_MEMWB;
            end

            S_MEMWB: begin
                bus.regwrite  = 1'b1;
                bus.resultsrc = 2'b01;
                state_d       = S_FETCH;
            end

            S_MEMWR: begin
                bus.adrsrc   = 1'b1;
                bus.memwrite = 1'b1;
                if (mem_ok) state_d = S_FETCH;
            end

            S_BRANCH: begin
                bus.alusrcb    = 2'b01;
                bus.immsrc     = 2'b10;
                bus.alucontrol = ALU_ADD;
                bus.resultsrc  = 2'b10;
                bus.pcwrite    = 1'b1;
                state_d        = S_FETCH;
            end

            S_LDI: begin
                bus.immsrc    = 2'b11;
                bus.resultsrc = 2'b11;
                bus.regwrite  = 1'b1;
                state_d       = S_FETCH;
            end

            default: state_d = S_RST;
        endcase
    end

    assign bus.flags = flags_q;
    assign bus.state = state_q;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed bench for multicycle_controller
module tb_multicycle_controller;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multicycle_controller_if #(.INSTR_W(16), .ALUCTL_W(5)) bus();

    multicycle_controller #(.INSTR_W(16), .ALUCTL_W(5), .ALU_ADD(5'd0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int mw_cnt   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [17:0] cv(input logic cf, input logic irw, input logic pcw,
                                       input logic adr, input logic mw, input logic rw,
                                       input logic [1:0] rs, input logic asa, input logic [1:0] asb,
                                       input logic [4:0] ac, input logic [1:0] imm);
        return {cf, irw, pcw, adr, mw, rw, rs, asa, asb, ac, imm};
    endfunction

    function automatic logic [15:0] mk(input logic [3:0] cond, input logic [1:0] op,
                                       input logic sl, input logic [4:0] fn);
        return {cond, op, sl, fn, 4'b1010};
    endfunction

    logic [17:0] ctl;
    assign ctl = {bus.cond_fail, bus.irwrite, bus.pcwrite, bus.adrsrc, bus.memwrite, bus.regwrite,
                  bus.resultsrc, bus.alusrca, bus.alusrcb, bus.alucontrol, bus.immsrc};

    always @(posedge clk) if (bus.memwrite) mw_cnt++;

    logic [17:0] c_fetch, c_fail, c_aluwb, c_memadr, c_memrd, c_memwb, c_memwr, c_branch, c_ldi;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [3:0] st, input logic [17:0] c);
        check({tag, "_state"}, 32'(bus.state), 32'(st));
        check({tag, "_ctl"}, 32'(ctl), 32'(c));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int low;
        int rd_cycles;
        c_fetch  = cv(0, 1, 1, 0, 0, 0, 2'd2, 0, 2'd2, 5'd0, 2'd0);
        c_fail   = cv(1, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 5'd0, 2'd0);
        c_aluwb  = cv(0, 0, 0, 0, 0, 1, 2'd0, 0, 2'd0, 5'd0, 2'd0);
        c_memadr = cv(0, 0, 0, 0, 0, 0, 2'd0, 1, 2'd1, 5'd0, 2'd1);
        c_memrd  = cv(0, 0, 0, 1, 0, 0, 2'd0, 0, 2'd0, 5'd0, 2'd0);
        c_memwb  = cv(0, 0, 0, 0, 0, 1, 2'd1, 0, 2'd0, 5'd0, 2'd0);
        c_memwr  = cv(0, 0, 0, 1, 1, 0, 2'd0, 0, 2'd0, 5'd0, 2'd0);
        c_branch = cv(0, 0, 1, 0, 0, 0, 2'd2, 0, 2'd1, 5'd0, 2'd2);
        c_ldi    = cv(0, 0, 0, 0, 0, 1, 2'd3, 0, 2'd0, 5'd0, 2'd3);

        reset         = 1'b0;
        bus.instr     = '0;
        bus.alu_flags = 4'b0000;
        bus.mem_ready = 1'b1;

        repeat (3) begin
            step();
            chk("rst", 4'd0, 18'd0);
            check("rst_flags", 32'(bus.flags), 32'h0);
        end
        reset = 1'b1;
        step();
        chk("fetch0", 4'd1, c_fetch);

        // ADD with S=1, AL
        bus.instr = mk(4'hE, 2'b00, 1'b1, 5'b00100);
        bus.alu_flags = 4'b0100;
        step(); chk("add_dec", 4'd2, 18'd0);
        step(); chk("add_exec", 4'd3, cv(0, 0, 0, 0, 0, 0, 2'd0, 1, 2'd0, 5'b00100, 2'd0));
        step(); chk("add_wb", 4'd4, c_aluwb);
        check("add_flags_wb", 32'(bus.flags), 32'h0);
        step(); chk("add_fetch", 4'd1, c_fetch);
        check("add_flags", 32'(bus.flags), 32'h4);

        // DP with S=0, immediate operand: flags must hold
        bus.instr = mk(4'hE, 2'b00, 1'b0, 5'b10011);
        bus.alu_flags = 4'b1010;
        step(); chk("dps0_dec", 4'd2, 18'd0);
        step(); chk("dps0_exec", 4'd3, cv(0, 0, 0, 0, 0, 0, 2'd0, 1, 2'd1, 5'b10011, 2'd0));
        step(); chk("dps0_wb", 4'd4, c_aluwb);
        step(); chk("dps0_fetch", 4'd1, c_fetch);
        check("dps0_flags", 32'(bus.flags), 32'h4);

        // BNE with Z=1 fails
        bus.instr = mk(4'h1, 2'b10, 1'b0, 5'd0);
        step(); chk("bne_dec", 4'd2, c_fail);
        step(); chk("bne_fetch", 4'd1, c_fetch);

        // BEQ with Z=1 branches
        bus.instr = mk(4'h0, 2'b10, 1'b0, 5'd0);
        step(); chk("beq_dec", 4'd2, 18'd0);
        step(); chk("beq_br", 4'd9, c_branch);
        step(); chk("beq_fetch", 4'd1, c_fetch);

        // NV never executes
        bus.instr = mk(4'hF, 2'b11, 1'b0, 5'd0);
        step(); chk("nv_dec", 4'd2, c_fail);
        step(); chk("nv_fetch", 4'd1, c_fetch);

        // LI under GE (N==V) executes
        bus.instr = mk(4'hA, 2'b11, 1'b0, 5'd0);
        step(); chk("li_dec", 4'd2, 18'd0);
        step(); chk("li_ldi", 4'd10, c_ldi);
        step(); chk("li_fetch", 4'd1, c_fetch);

        // DP S=1 under LT fails, flags untouched
        bus.instr = mk(4'hB, 2'b00, 1'b1, 5'd0);
        bus.alu_flags = 4'b1111;
        step(); chk("lt_dec", 4'd2, c_fail);
        step(); chk("lt_fetch", 4'd1, c_fetch);
        check("lt_flags", 32'(bus.flags), 32'h4);

        // LDR
        bus.instr = mk(4'hE, 2'b01, 1'b1, 5'd0);
        step(); chk("ldr_dec", 4'd2, 18'd0);
        step(); chk("ldr_adr", 4'd5, c_memadr);
        step(); chk("ldr_rd", 4'd6, c_memrd);
        step(); chk("ldr_wb", 4'd7, c_memwb);
        step(); chk("ldr_fetch", 4'd1, c_fetch);
        check("ldr_flags", 32'(bus.flags), 32'h4);

        // STR: memwrite exactly one cycle
        bus.instr = mk(4'hE, 2'b01, 1'b0, 5'd0);
        mw_cnt = 0;
        step(); chk("str_dec", 4'd2, 18'd0);
        step(); chk("str_adr", 4'd5, c_memadr);
        step(); chk("str_wr", 4'd8, c_memwr);
        step(); chk("str_fetch", 4'd1, c_fetch);
        check("str_mw_cnt", 32'(mw_cnt), 32'd1);

        // STR aborted by reset in MEMADR
        step(); step();
        chk("abort_adr", 4'd5, c_memadr);
        mw_cnt = 0;
        reset = 1'b0;
        #1;
        chk("abort_rst", 4'd0, 18'd0);
        check("abort_flags", 32'(bus.flags), 32'h0);
        step();
        chk("abort_hold", 4'd0, 18'd0);
        reset = 1'b1;
        step(); chk("abort_fetch", 4'd1, c_fetch);
        step(); step();
        check("abort_mw_cnt", 32'(mw_cnt), 32'd0);
        chk("abort_re_adr", 4'd5, c_memadr);
        step(); step();
        chk("abort_re_fetch", 4'd1, c_fetch);

        // LDR with mem_ready low for 3 cycles in MEMRD
        bus.instr = mk(4'hE, 2'b01, 1'b1, 5'd0);
        step(); step(); step();
        chk("wait_rd", 4'd6, c_memrd);
        bus.mem_ready = 1'b0;
        lat = 4;
        low = 1;
        rd_cycles = 1;
        while (bus.state != 4'd1 && lat < 30) begin
            step();
            lat++;
            if (bus.state == 4'd6) rd_cycles++;
            if (low < 3) low++;
            else bus.mem_ready = 1'b1;
        end
        bus.mem_ready = 1'b1;
`ifdef MCCTRL_MEM_WAIT_EN
        check("wait_lat", 32'(lat - 1), 32'd8);
        check("wait_rd_cycles", 32'(rd_cycles), 32'd4);
`else
        check("wait_lat", 32'(lat - 1), 32'd5);
        check("wait_rd_cycles", 32'(rd_cycles), 32'd1);
`endif
        chk("wait_fetch", 4'd1, c_fetch);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
